// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers.
// Defaults describe 640x480@60 with a 25 MHz pixel rate from 50 MHz.
package vga_timing_pkg;

    // Sync polarity encodings: the level hsync/vsync take inside the pulse.
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    localparam int DEF_CLK_DIV   = 2;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Positions per line (or lines per frame) including all blanking.
    function automatic int line_total(
        input int visible,
        input int front,
        input int sync,
        input int back
    );
        return visible + front + sync + back;
    endfunction

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_H_TOTAL = line_total(
        DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = line_total(
        DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    localparam int DEF_HW = cnt_width(DEF_H_TOTAL);
    localparam int DEF_VW = cnt_width(DEF_V_TOTAL);

endpackage

// File: rtl/generador_sinc_vga_if.sv
// Bundle between the VGA timing generator and the pixel/colour logic.
// master: takes en, drives sync, coordinates and strobes. slave: mirror.
interface generador_sinc_vga_if #(
    parameter int HW = vga_timing_pkg::DEF_HW,
    parameter int VW = vga_timing_pkg::DEF_VW
);

    logic          en;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [HW-1:0] pixel_x;
    logic [VW-1:0] pixel_y;
    logic          pixel_tick;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  en,
        output hsync,
        output vsync,
        output video_on,
        output pixel_x,
        output pixel_y,
        output pixel_tick,
        output line_start,
        output frame_start
    );

    modport slave (
        output en,
        input  hsync,
        input  vsync,
        input  video_on,
        input  pixel_x,
        input  pixel_y,
        input  pixel_tick,
        input  line_start,
        input  frame_start
    );

endinterface

// File: rtl/generador_tick_pixel.sv
// Clock divider producing one advance request every CLK_DIV enabled clocks.
// Ports: clk, rst_n (async, active-low), en (freeze when low), tick (comb).
module generador_tick_pixel
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int DW = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    if (CLK_DIV < 1) begin : g_bad_div
        $error("generador_tick_pixel: CLK_DIV must be >= 1");
    end

    // With CLK_DIV=1 the divider sits at 0 and tick simply follows en.
    assign tick = en && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (tick) begin
            div_d = '0;
        end else if (en) begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/generador_sinc_vga.sv
// Parametrised VGA timing generator: pixel counters, sync, video window.
// Ports: clk, rst_n (async, active-low), vga (master: en in, timing out).
module generador_sinc_vga
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic H_POL     = SYNC_ACTIVE_LOW,
    parameter logic V_POL     = SYNC_ACTIVE_LOW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    generador_sinc_vga_if.master vga
);

    localparam int H_TOTAL = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);

    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    if (H_BACK < 1 || V_BACK < 1) begin : g_bad_back
        $error("generador_sinc_vga: back porches must be >= 1");
    end

    if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
        $error("generador_sinc_vga: sync widths must be >= 1");
    end

    logic          adv;

    logic [HW-1:0] x_q;
    logic [HW-1:0] x_d;
    logic [VW-1:0] y_q;
    logic [VW-1:0] y_d;

    logic          hs_q;
    logic          hs_d;
    logic          vs_q;
    logic          vs_d;
    logic          von_q;
    logic          von_d;
    logic          pt_q;
    logic          pt_d;
    logic          ls_q;
    logic          ls_d;
    logic          fs_q;
    logic          fs_d;

    generador_tick_pixel #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (vga.en),
        .tick  (adv)
    );

    // Position counters: x wraps every line, y advances only on that wrap.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (adv) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Level outputs decode the next position so they land on the same edge
    // as the counters; with no advance x_d/y_d equal the held values.
    always_comb begin
        hs_d  = ~H_POL;
        vs_d  = ~V_POL;
        if (x_d >= HS_FIRST && x_d <= HS_LAST) begin
            hs_d = H_POL;
        end
        if (y_d >= VS_FIRST && y_d <= VS_LAST) begin
            vs_d = V_POL;
        end
        von_d = (x_d < H_VIS) && (y_d < V_VIS);
        pt_d  = adv;
        ls_d  = adv && (x_d == '0);
        fs_d  = ls_d && (y_d == '0);
    end

    // Reset parks on the last blanked pixel so the first tick opens a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= H_LAST;
            y_q   <= V_LAST;
            hs_q  <= ~H_POL;
            vs_q  <= ~V_POL;
            von_q <= 1'b0;
            pt_q  <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            von_q <= von_d;
            pt_q  <= pt_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
        end
    end

    assign vga.pixel_x     = x_q;
    assign vga.pixel_y     = y_q;
    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;
    assign vga.video_on    = von_q;
    assign vga.pixel_tick  = pt_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_generador_sinc_vga.sv
// Testbench for generador_sinc_vga on a reduced 29x15 raster.
// Two instances: CLK_DIV=2 active-low sync, CLK_DIV=1 active-high sync.
`timescale 1ns/1ps
module tb_generador_sinc_vga;
    import vga_timing_pkg::*;

    localparam int HV = 16;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 3;
    localparam int VV = 8;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int HWB = cnt_width(HT);
    localparam int VWB = cnt_width(VT);
    localparam int CDA = 2;
    localparam int CDB = 1;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       ls;
        logic       fs;
    } exp_t;

    typedef struct {
        int   n;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    always #5 clk = ~clk;

    generador_sinc_vga_if #(.HW(HWB), .VW(VWB)) bus_a ();
    generador_sinc_vga_if #(.HW(HWB), .VW(VWB)) bus_b ();

    assign bus_a.en = en;
    assign bus_b.en = en;

    generador_sinc_vga #(
        .CLK_DIV(CDA), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS),
        .H_BACK(HB), .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS),
        .V_BACK(VB), .H_POL(SYNC_ACTIVE_LOW), .V_POL(SYNC_ACTIVE_LOW)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (bus_a)
    );

    generador_sinc_vga #(
        .CLK_DIV(CDB), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS),
        .H_BACK(HB), .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS),
        .V_BACK(VB), .H_POL(SYNC_ACTIVE_HIGH), .V_POL(SYNC_ACTIVE_HIGH)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (bus_b)
    );

    exp_t obs_a;
    exp_t obs_b;
    assign obs_a = {8'(bus_a.pixel_x), 8'(bus_a.pixel_y), bus_a.hsync,
                    bus_a.vsync, bus_a.video_on, bus_a.pixel_tick,
                    bus_a.line_start, bus_a.frame_start};
    assign obs_b = {8'(bus_b.pixel_x), 8'(bus_b.pixel_y), bus_b.hsync,
                    bus_b.vsync, bus_b.video_on, bus_b.pixel_tick,
                    bus_b.line_start, bus_b.frame_start};

    int n_cmp = 0;
    int n_bad = 0;
    int ticks_a = 0;

    task automatic chk(input string name, input exp_t got, input exp_t req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s t=%0t: got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ls=%b fs=%b, required x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ls=%b fs=%b",
                    name, $time, got.x, got.y, got.hs, got.vs, got.von,
                    got.pt, got.ls, got.fs, req.x, req.y, req.hs, req.vs,
                    req.von, req.pt, req.ls, req.fs);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0d, required %0d",
                     name, $time, got, req);
        end
    endtask

    function automatic exp_t mke(input int x, input int y, input bit hs,
                                 input bit vs, input bit von, input bit pt,
                                 input bit ls, input bit fs);
        exp_t e;
        e.x = 8'(x);
        e.y = 8'(y);
        e.hs = hs;
        e.vs = vs;
        e.von = von;
        e.pt = pt;
        e.ls = ls;
        e.fs = fs;
        return e;
    endfunction

    function automatic vec_t mkv(input int n, input int x, input int y,
                                 input bit hs, input bit vs, input bit von,
                                 input bit pt, input bit ls, input bit fs);
        vec_t v;
        v.n = n;
        v.e = mke(x, y, hs, vs, von, pt, ls, fs);
        return v;
    endfunction

    // Reference: position derived from ticks elapsed since reset release.
    function automatic exp_t model(input int n, input bit tk,
                                   input bit hp, input bit vp);
        int x;
        int y;
        bit hs;
        bit vs;
        if (n == 0) begin
            x = HT - 1;
            y = VT - 1;
        end else begin
            x = (n - 1) % HT;
            y = ((n - 1) / HT) % VT;
        end
        hs = (x >= HV + HF && x < HV + HF + HS) ? hp : !hp;
        vs = (y >= VV + VF && y < VV + VF + VS) ? vp : !vp;
        return mke(x, y, hs, vs, (x < HV) && (y < VV), tk,
                   tk && (x == 0), tk && (x == 0) && (y == 0));
    endfunction

    int div_a;
    int div_b;
    int mn_a;
    int mn_b;
    bit tk_a;
    bit tk_b;
    exp_t qa[$];
    exp_t qb[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            div_a = 0; mn_a = 0; tk_a = 0;
            div_b = 0; mn_b = 0; tk_b = 0;
        end else begin
            tk_a = 0;
            tk_b = 0;
            if (en) begin
                if (div_a == CDA - 1) begin
                    div_a = 0; mn_a++; tk_a = 1;
                end else begin
                    div_a++;
                end
                if (div_b == CDB - 1) begin
                    div_b = 0; mn_b++; tk_b = 1;
                end else begin
                    div_b++;
                end
            end
        end
        qa.push_back(model(mn_a, tk_a, 1'b0, 1'b0));
        qb.push_back(model(mn_b, tk_b, 1'b1, 1'b1));
    end

    always @(negedge clk) begin
        if (qa.size() > 0) chk("scoreboard_a", obs_a, qa.pop_front());
        if (qb.size() > 0) chk("scoreboard_b", obs_b, qb.pop_front());
    end

    task automatic step();
        @(negedge clk);
        #1;
        if (bus_a.pixel_tick) ticks_a++;
    endtask

    task automatic wait_ticks(input int n);
        int g = 0;
        while (ticks_a < n && g < 1000) begin
            step();
            g++;
        end
        if (ticks_a < n) chk_int("wait_ticks_timeout", ticks_a, n);
    endtask

    vec_t tab[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int g;
        int k;
        int cyc, lsc, vonc, vsl, hsc, fsb, ptb, hsb;
        int hsa, strobes, first_x;

        tab.push_back(mkv(  0, 28, 14, 1, 1, 0, 0, 0, 0));
        tab.push_back(mkv(  1,  0,  0, 1, 1, 1, 1, 1, 1));
        tab.push_back(mkv( 16, 15,  0, 1, 1, 1, 1, 0, 0));
        tab.push_back(mkv( 17, 16,  0, 1, 1, 0, 1, 0, 0));
        tab.push_back(mkv( 20, 19,  0, 1, 1, 0, 1, 0, 0));
        tab.push_back(mkv( 21, 20,  0, 0, 1, 0, 1, 0, 0));
        tab.push_back(mkv( 26, 25,  0, 0, 1, 0, 1, 0, 0));
        tab.push_back(mkv( 27, 26,  0, 1, 1, 0, 1, 0, 0));
        tab.push_back(mkv( 29, 28,  0, 1, 1, 0, 1, 0, 0));
        tab.push_back(mkv( 30,  0,  1, 1, 1, 1, 1, 1, 0));
        tab.push_back(mkv(219, 15,  7, 1, 1, 1, 1, 0, 0));
        tab.push_back(mkv(220, 16,  7, 1, 1, 0, 1, 0, 0));
        tab.push_back(mkv(233,  0,  8, 1, 1, 0, 1, 1, 0));
        tab.push_back(mkv(262,  0,  9, 1, 1, 0, 1, 1, 0));
        tab.push_back(mkv(291,  0, 10, 1, 0, 0, 1, 1, 0));
        tab.push_back(mkv(320,  0, 11, 1, 0, 0, 1, 1, 0));
        tab.push_back(mkv(349,  0, 12, 1, 1, 0, 1, 1, 0));
        tab.push_back(mkv(435, 28, 14, 1, 1, 0, 1, 0, 0));
        tab.push_back(mkv(436,  0,  0, 1, 1, 1, 1, 1, 1));

        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) step();
        rst_n   = 1'b1;
        ticks_a = 0;

        foreach (tab[i]) begin
            wait_ticks(tab[i].n);
            chk($sformatf("vec_n%0d", tab[i].n), obs_a, tab[i].e);
        end

        // Full frame window starting on this frame_start.
        cyc = 0; lsc = 0; vonc = 0; vsl = 0;
        hsc = 0; fsb = 0; ptb = 0; hsb = 0;
        do begin
            if (bus_a.line_start) lsc++;
            if (bus_a.pixel_tick && bus_a.video_on) vonc++;
            if (bus_a.line_start && !bus_a.vsync) vsl++;
            if (bus_a.pixel_tick && !bus_a.hsync) hsc++;
            if (bus_b.frame_start) fsb++;
            if (bus_b.pixel_tick) ptb++;
            if (bus_b.pixel_tick && bus_b.hsync) hsb++;
            step();
            cyc++;
        end while (!bus_a.frame_start && cyc < 2000);
        chk_int("frame_clks_a", cyc, HT * VT * CDA);
        chk_int("line_starts_a", lsc, VT);
        chk_int("video_on_ticks_a", vonc, HV * VV);
        chk_int("vsync_lines_a", vsl, VS);
        chk_int("hsync_ticks_a", hsc, HS * VT);
        chk_int("frames_b", fsb, 2);
        chk_int("ticks_b", ptb, HT * VT * CDA);
        chk_int("hsync_ticks_b", hsb, 2 * HS * VT);

        // Freeze inside the hsync pulse with the divider mid-count.
        hsa = 0;
        g = 0;
        while (!(bus_a.pixel_x == 5'd22 && bus_a.pixel_tick) && g < 200) begin
            step();
            g++;
            if (bus_a.pixel_tick && !bus_a.hsync) hsa++;
        end
        chk_int("reach_x22", int'(bus_a.pixel_x), 22);
        step();
        en = 1'b0;
        strobes = 0;
        repeat (50) begin
            step();
            if (bus_a.pixel_tick || bus_a.line_start || bus_a.frame_start)
                strobes++;
        end
        chk_int("freeze_strobes", strobes, 0);
        chk_int("freeze_x", int'(bus_a.pixel_x), 22);
        chk_int("freeze_hsync", int'(bus_a.hsync), 0);
        en = 1'b1;
        g = 0;
        k = -1;
        first_x = -1;
        while (!bus_a.line_start && g < 200) begin
            step();
            g++;
            if (bus_a.pixel_tick && first_x < 0) begin
                first_x = int'(bus_a.pixel_x);
                k = g;
            end
            if (bus_a.pixel_tick && !bus_a.hsync) hsa++;
        end
        chk_int("resume_x", first_x, 23);
        chk_int("resume_latency", k, 1);
        chk_int("hsync_ticks_freeze_line", hsa, HS);

        // Asynchronous reset with both syncs active.
        g = 0;
        while (!(bus_a.pixel_x == 5'd23 && bus_a.pixel_y == 4'd11 &&
                 bus_a.pixel_tick) && g < 2000) begin
            step();
            g++;
        end
        chk_int("reach_x23_y11", int'(bus_a.pixel_y), 11);
        rst_n = 1'b0;
        #1;
        chk("async_reset_a", obs_a, mke(28, 14, 1, 1, 0, 0, 0, 0));
        chk("async_reset_b", obs_b, mke(28, 14, 0, 0, 0, 0, 0, 0));
        repeat (3) step();
        rst_n   = 1'b1;
        ticks_a = 0;
        k = 0;
        while (ticks_a < 1 && k < 10) begin
            step();
            k++;
        end
        chk_int("recovery_latency", k, CDA);
        foreach (tab[i]) begin
            if (tab[i].n >= 1 && tab[i].n <= 30) begin
                wait_ticks(tab[i].n);
                chk($sformatf("recovery_n%0d", tab[i].n), obs_a, tab[i].e);
            end
        end

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
